// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported, fixed-latency memory between
// the instruction-fetch port and the load/store port. One transaction is in
// flight at a time; each grant produces exactly one memory strobe and exactly
// one completion pulse back to the requester that won.
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant, latch the winner's command
// ISSUE | drive mem_en for one cycle with the latched command
// WAIT  | read in flight; down-counter spans the memory latency
// RESP  | pulse the winner's rvalid for one cycle
module mem_port_arbiter #(
   parameter int s   = 32,
   parameter int LAT = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         if_req,
   input  logic [s-1:0] if_addr,
   output logic         if_gnt,
   output logic         if_rvalid,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [s-1:0] d_addr,
   input  logic [s-1:0] d_wdata,
   output logic         d_gnt,
   output logic         d_rvalid,
   output logic [s-1:0] rsp_data,
   output logic         mem_en,
   output logic         mem_we,
   output logic [s-1:0] mem_addr,
   output logic [s-1:0] mem_wdata,
   input  logic [s-1:0] mem_rdata,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // The counter is loaded on the ISSUE->WAIT edge so that WAIT lasts LAT cycles.
   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t         state, state_nxt;
   logic           last_data;
   logic           lat_data;
   logic           lat_we;
   logic [s-1:0]   lat_addr;
   logic [s-1:0]   lat_wdata;
   logic [3:0]     cnt;
   logic           cnt_done;
   logic           grant_any;
   logic           grant_data;

   // Arbitration: only in IDLE, never while reset is asserted; a tie goes to
   // whichever port did not win last time.
   always_comb begin
      if_gnt     = 1'b0;
      d_gnt      = 1'b0;
      grant_data = 1'b0;
      if (state == IDLE && reset) begin
         if (if_req && d_req) begin
            grant_data = ~last_data;
         end else begin
            grant_data = d_req;
         end
         if_gnt = (if_req | d_req) & ~grant_data;
         d_gnt  = (if_req | d_req) &  grant_data;
      end
   end

   assign grant_any = if_gnt | d_gnt;
   assign cnt_done  = (cnt == 4'd0);

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ISSUE;
         ISSUE:   state_nxt = lat_we ? RESP : WAIT;
         WAIT:    if (cnt_done) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Command latch and round-robin history, both updated only on a grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_data <= 1'b1;
         lat_data  <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant_any) begin
         last_data <= grant_data;
         lat_data  <= grant_data;
         lat_we    <= grant_data & d_we;
         lat_addr  <= grant_data ? d_addr : if_addr;
         lat_wdata <= grant_data ? d_wdata : '0;
      end
   end

   // Latency down-counter; terminal count marks the cycle mem_rdata is valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= 4'd0;
      end else if (state == ISSUE) begin
         cnt <= CNT_LOAD;
      end else if (state == WAIT && !cnt_done) begin
         cnt <= cnt - 4'd1;
      end
   end

   // Read response register; writes leave it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_data <= '0;
      end else if (state == WAIT && cnt_done) begin
         rsp_data <= mem_rdata;
      end
   end

   // Memory side is forced to zero outside the single ISSUE cycle.
   always_comb begin
      mem_en    = (state == ISSUE);
      mem_we    = mem_en & lat_we;
      mem_addr  = mem_en ? lat_addr  : '0;
      mem_wdata = mem_en ? lat_wdata : '0;
      if_rvalid = (state == RESP) & ~lat_data;
      d_rvalid  = (state == RESP) &  lat_data;
      busy      = (state != IDLE);
   end

endmodule
